// File: rtl/phase_update_ctrl_pkg.sv
// Shared constants, FSM encoding and width helpers for the phase update controller.
package phase_update_ctrl_pkg;

  localparam int NUM_CH_DEF       = 16;
  localparam int OFFSET_WIDTH_DEF = 11;
  localparam int DIVIDE_DEF       = 624;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_APPLY     = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  // wr_ch is one bit wider than a bare index so out-of-range channels reach the range check
  function automatic int ch_idx_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

  function automatic int ref_cnt_width(input int divide);
    return $clog2(2 * (divide + 1));
  endfunction

endpackage

// File: rtl/phase_update_ctrl_if.sv
// Offset-write and commit handshake bundle between a host and phase_update_ctrl.
interface phase_update_ctrl_if
  import phase_update_ctrl_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF
) ();

  localparam int CH_W = ch_idx_width(NUM_CH);

  logic                    wr_valid;
  logic                    wr_ready;
  logic [CH_W-1:0]         wr_ch;
  logic [OFFSET_WIDTH-1:0] wr_offset;
  logic                    commit_valid;
  logic                    commit_ready;

  modport master (
    output wr_valid, wr_ch, wr_offset, commit_valid,
    input  wr_ready, commit_ready
  );

  modport slave (
    input  wr_valid, wr_ch, wr_offset, commit_valid,
    output wr_ready, commit_ready
  );

endinterface

// File: rtl/phase_update_ctrl_ref_counter.sv
// Free-running period reference counter; flags the last tick of every period as the sync point.
module phase_ref_counter #(
  parameter int DIVIDE = 624,
  parameter int CNT_W  = 11
) (
  input  logic clk,
  input  logic rst,
  output logic sync
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * DIVIDE + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap at the end of the full period; never stalled so every commit lands on the same grid
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sync = (cnt_q == LAST);

endmodule

// File: rtl/phase_update_ctrl.sv
// Double-buffered channel offset bank; a commit swaps shadow into active on the next period
// boundary while holding the channel dividers in reload and their outputs disabled.
module phase_update_ctrl
  import phase_update_ctrl_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int DIVIDE       = DIVIDE_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  phase_update_ctrl_if.slave             bus,
  input  logic                           out_enable,
  output logic [NUM_CH*OFFSET_WIDTH-1:0] ch_offset,
  output logic                           ch_rst,
  output logic [OFFSET_WIDTH-2:0]        ch_divide,
  output logic                           ch_oe,
  output logic                           commit_done,
  output logic                           wr_err
);

  localparam int CH_W  = ch_idx_width(NUM_CH);
  localparam int CNT_W = ref_cnt_width(DIVIDE);
  localparam int DIV_W = OFFSET_WIDTH - 1;
  localparam int BANK_W = NUM_CH * OFFSET_WIDTH;

  state_t            state_q, state_d;
  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              wr_ready_q, wr_ready_d;
  logic              commit_ready_q, commit_ready_d;
  logic              ch_rst_q, ch_rst_d;
  logic              ch_oe_q, ch_oe_d;
  logic              commit_done_q, commit_done_d;
  logic              wr_err_q, wr_err_d;
  logic              sync;
  logic              wr_fire;
  logic              commit_fire;
  logic              swap_phase;

  phase_ref_counter #(
    .DIVIDE (DIVIDE),
    .CNT_W  (CNT_W)
  ) u_ref (
    .clk  (clk),
    .rst  (rst),
    .sync (sync)
  );

  assign wr_fire     = bus.wr_valid & wr_ready_q;
  assign commit_fire = bus.commit_valid & commit_ready_q;

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_fire) state_d = ST_WAIT_SYNC;
        else             state_d = ST_IDLE;
      end
      ST_WAIT_SYNC: begin
        if (sync) state_d = ST_APPLY;
        else      state_d = ST_WAIT_SYNC;
      end
      ST_APPLY:   state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Shadow writes (a write alongside a commit still lands first) and the active swap
  always_comb begin
    shadow_d = shadow_q;
    wr_err_d = wr_err_q;
    if (wr_fire) begin
      if (bus.wr_ch >= CH_W'(NUM_CH)) begin
        wr_err_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (bus.wr_ch == CH_W'(i)) shadow_d[i*OFFSET_WIDTH +: OFFSET_WIDTH] = bus.wr_offset;
        end
      end
    end else begin
      wr_err_d = wr_err_q;
    end
    if (state_d == ST_APPLY) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state
  always_comb begin
    swap_phase     = (state_d == ST_APPLY) || (state_d == ST_RELEASE);
    wr_ready_d     = (state_d == ST_IDLE);
    commit_ready_d = (state_d == ST_IDLE);
    commit_done_d  = (state_d == ST_RELEASE);
    if (swap_phase) begin
      ch_rst_d = 1'b0;
      ch_oe_d  = 1'b0;
    end else begin
      ch_rst_d = 1'b1;
      ch_oe_d  = out_enable;
    end
  end

  // State, banks and registered outputs; reset drops every strobe and enable low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      shadow_q       <= '0;
      active_q       <= '0;
      wr_ready_q     <= 1'b0;
      commit_ready_q <= 1'b0;
      ch_rst_q       <= 1'b0;
      ch_oe_q        <= 1'b0;
      commit_done_q  <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      wr_ready_q     <= wr_ready_d;
      commit_ready_q <= commit_ready_d;
      ch_rst_q       <= ch_rst_d;
      ch_oe_q        <= ch_oe_d;
      commit_done_q  <= commit_done_d;
      wr_err_q       <= wr_err_d;
    end
  end

  assign bus.wr_ready     = wr_ready_q;
  assign bus.commit_ready = commit_ready_q;
  assign ch_offset        = active_q;
  assign ch_rst           = ch_rst_q;
  assign ch_divide        = DIV_W'(DIVIDE);
  assign ch_oe            = ch_oe_q;
  assign commit_done      = commit_done_q;
  assign wr_err           = wr_err_q;

endmodule

// File: tb/tb_phase_update_ctrl.sv
// Bench for phase_update_ctrl: timeline reference model checked every cycle, plus directed sequences.
module tb_phase_update_ctrl;
  import phase_update_ctrl_pkg::*;

  localparam int NCH = 16;
  localparam int OW  = 11;
  localparam int DIV = 624;
  localparam int PER = 2 * (DIV + 1);
  localparam int CHW = ch_idx_width(NCH);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              out_enable = 1'b0;
  logic [NCH*OW-1:0] ch_offset;
  logic              ch_rst;
  logic [OW-2:0]     ch_divide;
  logic              ch_oe;
  logic              commit_done;
  logic              wr_err;

  phase_update_ctrl_if #(.NUM_CH(NCH), .OFFSET_WIDTH(OW)) bus ();

  phase_update_ctrl #(.NUM_CH(NCH), .OFFSET_WIDTH(OW), .DIVIDE(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .out_enable  (out_enable),
    .ch_offset   (ch_offset),
    .ch_rst      (ch_rst),
    .ch_divide   (ch_divide),
    .ch_oe       (ch_oe),
    .commit_done (commit_done),
    .wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  // Model: k = clock edges since reset release, so ref_cnt in cycle k is k mod PER.
  int  k, ta, n_vec, n_bad;
  bit  busy, m_ready, m_err;
  logic [OW-1:0] m_shadow [NCH];
  logic [OW-1:0] m_active [NCH];

  typedef struct {
    logic [CHW-1:0] ch;
    logic [OW-1:0]  off;
    bit             exp_err;
  } wvec_t;
  wvec_t tbl [8];

  task automatic chk(input string name, input logic [NCH*OW-1:0] act, input logic [NCH*OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s cycle %0d: bound expired", name, k);
  endtask

  function automatic int first_sync_after(input int tc);
    int s;
    s = tc + 1;
    return s + ((PER - 1 - (s % PER)) % PER);
  endfunction

  function automatic logic [OW-1:0] lane(input logic [NCH*OW-1:0] v, input int ch);
    return v[ch*OW +: OW];
  endfunction

  task automatic step();
    bit iv, icv, ioe, in_ar;
    logic [CHW-1:0] ich;
    logic [OW-1:0] ioff;
    logic [NCH*OW-1:0] exp_off;
    iv = bus.wr_valid; ich = bus.wr_ch; ioff = bus.wr_offset;
    icv = bus.commit_valid; ioe = out_enable;
    @(posedge clk);
    #1;
    k++;
    if (busy && k > ta + 1) busy = 1'b0;
    if (m_ready && iv) begin
      if (int'(ich) < NCH) m_shadow[ich] = ioff;
      else m_err = 1'b1;
    end
    if (m_ready && icv) begin
      busy = 1'b1;
      ta = first_sync_after(k - 1) + 1;
    end
    if (busy && k == ta) for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
    in_ar = busy && (k == ta || k == ta + 1);
    for (int i = 0; i < NCH; i++) exp_off[i*OW +: OW] = m_active[i];
    m_ready = !busy;
    chk("wr_ready", bus.wr_ready, m_ready);
    chk("commit_ready", bus.commit_ready, m_ready);
    chk("ch_rst", ch_rst, !in_ar);
    chk("ch_oe", ch_oe, in_ar ? 1'b0 : ioe);
    chk("commit_done", commit_done, busy && k == ta + 1);
    chk("wr_err", wr_err, m_err);
    chk("ch_offset", ch_offset, exp_off);
    chk("ch_divide", ch_divide, DIV);
  endtask

  task automatic idle_in();
    bus.wr_valid = 1'b0; bus.commit_valid = 1'b0;
    bus.wr_ch = '0; bus.wr_offset = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b0;
    #1;
    chk("rst_ch_rst", ch_rst, 1'b0);
    chk("rst_ch_oe", ch_oe, 1'b0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_commit_ready", bus.commit_ready, 1'b0);
    chk("rst_commit_done", commit_done, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_ch_offset", ch_offset, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_ch_rst", ch_rst, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    k = 0; busy = 1'b0; m_ready = 1'b0; m_err = 1'b0;
    for (int i = 0; i < NCH; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
  endtask

  task automatic wait_ref(input int target);
    int n;
    n = 0;
    while ((k % PER) != target && n <= PER) begin step(); n++; end
    if ((k % PER) != target) timeout("wait_ref");
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (commit_done !== 1'b1 && n < limit) begin step(); n++; end
    if (commit_done !== 1'b1) timeout("wait_done");
  endtask

  task automatic write_ch(input int ch, input int off);
    bus.wr_valid = 1'b1; bus.wr_ch = CHW'(ch); bus.wr_offset = OW'(off);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic commit_now();
    bus.commit_valid = 1'b1;
    step();
    bus.commit_valid = 1'b0;
  endtask

  initial begin
    int n, oe_low;
    logic [NCH*OW-1:0] exp_bank;
    n_vec = 0; n_bad = 0; k = 0;
    tbl[0] = '{5'd3,  11'h271, 1'b0};
    tbl[1] = '{5'd0,  11'h005, 1'b0};
    tbl[2] = '{5'd15, 11'h7FF, 1'b0};
    tbl[3] = '{5'd7,  11'h400, 1'b0};
    tbl[4] = '{5'd3,  11'h0AA, 1'b0};
    tbl[5] = '{5'd16, 11'h123, 1'b1};
    tbl[6] = '{5'd31, 11'h001, 1'b1};
    tbl[7] = '{5'd9,  11'h3C3, 1'b1};

    // Table: writes with sticky error, then one commit makes the last values live
    do_reset();
    step();
    for (int i = 0; i < 8; i++) begin
      write_ch(int'(tbl[i].ch), int'(tbl[i].off));
      chk("tbl_wr_err", wr_err, tbl[i].exp_err);
    end
    commit_now();
    wait_done(2 * PER, n);
    exp_bank = '0;
    exp_bank[0*OW +: OW] = 11'h005; exp_bank[3*OW +: OW] = 11'h0AA;
    exp_bank[7*OW +: OW] = 11'h400; exp_bank[9*OW +: OW] = 11'h3C3;
    exp_bank[15*OW +: OW] = 11'h7FF;
    chk("tbl_bank", ch_offset, exp_bank);

    // ch3=0x271 committed at ref_cnt=10, out_enable held high throughout
    do_reset();
    out_enable = 1'b1;
    wait_ref(5);
    write_ch(3, 'h271);
    wait_ref(10);
    commit_now();
    wait_ref(PER - 1);
    chk("pre_apply_lane3", lane(ch_offset, 3), 11'h000);
    chk("pre_apply_oe", ch_oe, 1'b1);
    oe_low = 0;
    step();
    chk("apply_lane3", lane(ch_offset, 3), 11'h271);
    chk("apply_ch_rst", ch_rst, 1'b0);
    if (ch_oe === 1'b0) oe_low++;
    step();
    chk("release_ch_rst", ch_rst, 1'b0);
    chk("release_done", commit_done, 1'b1);
    if (ch_oe === 1'b0) oe_low++;
    step();
    chk("after_ch_rst", ch_rst, 1'b1);
    chk("after_done", commit_done, 1'b0);
    chk("after_oe", ch_oe, 1'b1);
    chk("oe_low_cycles", oe_low, 2);

    // Write+commit in the sync cycle waits a full period; a held write stalls during WAIT_SYNC
    wait_ref(PER - 1);
    bus.wr_valid = 1'b1; bus.wr_ch = 5'd0; bus.wr_offset = 11'h005;
    bus.commit_valid = 1'b1;
    step();
    bus.commit_valid = 1'b0;
    bus.wr_ch = 5'd5; bus.wr_offset = 11'h111;
    wait_done(2 * PER, n);
    chk("sync_commit_latency", n, PER + 1);
    chk("sync_commit_lane0", lane(ch_offset, 0), 11'h005);
    chk("held_write_lane5", lane(ch_offset, 5), 11'h000);
    step();
    step();
    idle_in();
    commit_now();
    wait_done(2 * PER, n);
    chk("held_write_live", lane(ch_offset, 5), 11'h111);
    out_enable = 1'b0;

    // Out-of-range channel: accepted, dropped, sticky error
    do_reset();
    step();
    write_ch(16, 'h3FF);
    chk("oor_wr_err", wr_err, 1'b1);
    commit_now();
    wait_done(2 * PER, n);
    chk("oor_bank", ch_offset, '0);
    chk("oor_err_sticky", wr_err, 1'b1);

    // Reset in WAIT_SYNC aborts the commit
    do_reset();
    step();
    write_ch(2, 'h1AB);
    commit_now();
    repeat (100) step();
    do_reset();
    n = 0;
    for (int i = 0; i < PER + 20; i++) begin
      step();
      if (commit_done === 1'b1) n++;
    end
    chk("abort_no_done", n, 0);
    chk("abort_lane2", lane(ch_offset, 2), 11'h000);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bus.wr_valid = ($urandom_range(0, 9) < 3);
      bus.wr_ch = CHW'($urandom_range(0, 17));
      bus.wr_offset = OW'($urandom);
      bus.commit_valid = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) out_enable = ~out_enable;
      step();
    end
    idle_in();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/phase_update_ctrl.md
PHASE_UPDATE_CTRL -- requirements
Module: phase_update_ctrl

Interface
REQ-001 Parameter NUM_CH, 16, number of transducer clock channels driven.
REQ-002 Parameter OFFSET_WIDTH, 11, channel offset width: MSB is the initial output level, low bits are the counter preload.
REQ-003 Parameter DIVIDE, 624, half-period terminal count; full period is 2*(DIVIDE+1) clk ticks (1250 at 50 MHz).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 wr_valid  in  1  offset write request.
REQ-007 wr_ready  out  1  offset write accepted when wr_valid && wr_ready.
REQ-008 wr_ch  in  $clog2(NUM_CH)  target channel index.
REQ-009 wr_offset  in  OFFSET_WIDTH  new offset for wr_ch.
REQ-010 commit_valid  in  1  request to apply the shadow bank.
REQ-011 commit_ready  out  1  commit accepted when commit_valid && commit_ready.
REQ-012 out_enable  in  1  global output-enable request.
REQ-013 ch_offset  out  NUM_CH*OFFSET_WIDTH  active offsets; channel i occupies bits [i*OFFSET_WIDTH +: OFFSET_WIDTH].
REQ-014 ch_rst  out  1  active-low reload strobe to all channel dividers.
REQ-015 ch_divide  out  OFFSET_WIDTH-1  constant DIVIDE to channel dividers.
REQ-016 ch_oe  out  1  output enable to channels.
REQ-017 commit_done  out  1  one-cycle pulse when new offsets are live.
REQ-018 wr_err  out  1  sticky flag, out-of-range wr_ch seen.

Function
REQ-019 Shadow bank of NUM_CH offsets SHALL be written on each accepted write; the active bank (ch_offset) SHALL change only in APPLY.
REQ-020 Reference counter ref_cnt SHALL run 0..2*DIVIDE+1, wrapping to 0; sync point = ref_cnt == 2*DIVIDE+1.
REQ-021 FSM states: IDLE, WAIT_SYNC, APPLY, RELEASE.
REQ-022 IDLE: wr_ready=1, commit_ready=1; accepted commit -> WAIT_SYNC next cycle.
REQ-023 WAIT_SYNC: wr_ready=0, commit_ready=0; at sync point -> APPLY.
REQ-024 APPLY (1 cycle): copy shadow to active, ch_rst=0, ch_oe=0 -> RELEASE.
REQ-025 RELEASE (1 cycle): ch_rst=0, ch_oe=0; commit_done=1 -> IDLE.
REQ-026 Outside APPLY/RELEASE: ch_rst=1, ch_oe=out_enable.
REQ-027 Simultaneous accepted write and commit in IDLE: write SHALL land in shadow and be included in that commit.
REQ-028 Commit accepted in the cycle where ref_cnt is at sync point: SHALL wait for the next sync point (full period later).
REQ-029 wr_ch >= NUM_CH: write SHALL be accepted, dropped, and wr_err set until reset.
REQ-030 ref_cnt SHALL not be reset or stalled by commits, so all channels realign to the same period grid.
REQ-031 Write-to-live latency: commit accept -> ch_offset update at the first sync point strictly later, +1 cycle.

Reset
REQ-032 rst low SHALL asynchronously set: state=IDLE, ref_cnt=0, shadow and active banks=0, wr_err=0, commit_done=0.
REQ-033 During rst low: ch_rst=0, ch_oe=0, wr_ready=0, commit_ready=0.
REQ-034 Reset mid-WAIT_SYNC/APPLY SHALL abort the commit; no commit_done after release.

Structure
REQ-035 Shared package SHALL hold FSM state encoding, default OFFSET_WIDTH=11 and DIVIDE=624 constants.
REQ-036 ref_cnt plus sync-point decode SHALL be a sub-module phase_ref_counter; shadow/active banks stay in the top.

Verification
REQ-037 Write ch3=0x271, commit at ref_cnt=10 -> ch_offset[3]=0x271 at cycle after ref_cnt=1249, ch_rst low 2 cycles, commit_done 1 pulse.
REQ-038 Write ch0=0x005 and commit same cycle at ref_cnt=1249 -> apply after ref_cnt=1249 of next period (~1250 cycles later).
REQ-039 Write wr_ch=16 (NUM_CH=16) -> accepted, banks unchanged, wr_err=1 until rst.
REQ-040 wr_valid held during WAIT_SYNC -> wr_ready=0, shadow unchanged until return to IDLE.
REQ-041 out_enable=1 throughout commit -> ch_oe=0 exactly in APPLY and RELEASE, 1 otherwise.
REQ-042 rst pulsed low in WAIT_SYNC -> all offsets 0, ch_rst=0 during reset, no commit_done afterwards.
